// File: rtl/io_port_unit_pkg.sv
// Shared constants for the memory-mapped I/O port: controller phases,
// port direction register (PDR) bit positions, STATUS bit positions and
// the two bus addresses the port answers to.
package io_port_unit_pkg;

  // Controller phase, one clock cycle per phase
  typedef enum logic [1:0] {
    PH_FETCH   = 2'd0,
    PH_DECODE  = 2'd1,
    PH_EXECUTE = 2'd2,
    PH_UPDATE  = 2'd3
  } phase_e;

  // PDR bit positions
  localparam int PDR_TX_EN = 0;  // TX drain enable
  localparam int PDR_RX_EN = 1;  // RX capture enable
  localparam int PDR_LOOP  = 2;  // internal loopback (build option)

  // STATUS bit positions: {RX_AVAIL, TX_OVR, TX_FULL, TX_EMPTY}
  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_OVR   = 2;
  localparam int ST_RX_AVAIL = 3;

  // Bus addresses
  localparam logic [7:0] PORT_ADDR = 8'd67;
  localparam logic [7:0] PDR_ADDR  = 8'd66;

endpackage

// File: rtl/io_port_unit_if.sv
// Bus bundle for io_port_unit: controller strobes, CPU data buses and
// the external valid/ready TX and RX channels. The master side is the
// environment (controller plus external device), the slave side the port.
interface io_port_unit_if #(
  parameter int DATA_W = 8
) ();
  import io_port_unit_pkg::*;

  // Controller side
  phase_e              ph;
  logic [DATA_W-1:0]   data_in;
  logic                port_en;
  logic                pdr_en;
  logic                port_rd;
  logic                port_pop;
  logic [DATA_W-1:0]   data_out;
  logic                data_oe;
  logic [3:0]          status;

  // External device side
  logic [DATA_W-1:0]   ext_tx_data;
  logic                ext_tx_valid;
  logic                ext_tx_ready;
  logic [DATA_W-1:0]   ext_rx_data;
  logic                ext_rx_valid;
  logic                ext_rx_ready;

  modport master (
    output ph, data_in, port_en, pdr_en, port_rd, port_pop,
    output ext_tx_ready, ext_rx_data, ext_rx_valid,
    input  data_out, data_oe, status,
    input  ext_tx_data, ext_tx_valid, ext_rx_ready
  );

  modport slave (
    input  ph, data_in, port_en, pdr_en, port_rd, port_pop,
    input  ext_tx_ready, ext_rx_data, ext_rx_valid,
    output data_out, data_oe, status,
    output ext_tx_data, ext_tx_valid, ext_rx_ready
  );

endinterface

// File: rtl/io_port_unit_fifo.sv
// Synchronous transmit FIFO. Pointers wrap modulo DEPTH (power of two);
// the occupancy count is one bit wider than the pointers so that full and
// empty are distinguishable. The caller may push while full only when it
// pops in the same cycle, and pops only when non-empty.
module io_port_unit_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  // Pointer and occupancy bookkeeping
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage write
  // NOTE: the data array is deliberately not reset; empty/valid come from
  // the pointers, so stale contents are never observed as valid data.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/io_port_unit.sv
// Memory-mapped I/O port (address 67) with port direction register
// (address 66). CPU writes queue into a TX FIFO drained over a valid/ready
// handshake; one external byte is captured into an RX holding register for
// CPU reads. Commits happen only in the EXECUTE phase.
// Build option: IO_PORT_LOOPBACK_EN enables PDR[2] internal loopback from
// the TX head into the RX holding register.
module io_port_unit
  import io_port_unit_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  io_port_unit_if.slave bus
);

  logic [DATA_W-1:0] pdr;
  logic [DATA_W-1:0] rx_hold;
  logic              rx_avail;
  logic              tx_ovr;

  logic              exec_ph;
  logic              wr_cmd;
  logic              pdr_ld;
  logic              rx_pop;
  logic              rx_cap;
  logic              loop_on;
  logic              loop_xfer;
  logic              tx_valid;
  logic              rx_ready;
  logic              tx_drain;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              tx_overflow;
  logic [DATA_W-1:0] fifo_head;
  logic              unused_pdr;

  io_port_unit_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (bus.data_in),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Controller strobes only commit in EXECUTE
  assign exec_ph = (bus.ph == PH_EXECUTE);
  assign wr_cmd  = exec_ph && bus.port_en;
  assign pdr_ld  = exec_ph && bus.pdr_en;
  assign rx_pop  = exec_ph && bus.port_pop && rx_avail;

`ifdef IO_PORT_LOOPBACK_EN
  // Loopback moves the TX head into an empty RX holding register and
  // silences both external channels.
  assign loop_on   = pdr[PDR_LOOP];
  assign loop_xfer = loop_on && !fifo_empty && !rx_avail;
`else
  assign loop_on   = 1'b0;
  assign loop_xfer = 1'b0;
`endif

  // Upper PDR bits are storage only
  assign unused_pdr = ^pdr;

  // Handshake qualification, all from registered state
  assign tx_valid    = pdr[PDR_TX_EN] && !fifo_empty && !loop_on;
  assign rx_ready    = pdr[PDR_RX_EN] && !rx_avail && !loop_on;
  assign tx_drain    = tx_valid && bus.ext_tx_ready;
  assign rx_cap      = bus.ext_rx_valid && rx_ready;
  assign fifo_pop    = tx_drain || loop_xfer;
  assign fifo_push   = wr_cmd && (!fifo_full || fifo_pop);
  assign tx_overflow = wr_cmd && fifo_full && !fifo_pop;

  // Direction register and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pdr    <= '0;
      tx_ovr <= 1'b0;
    end else begin
      if (pdr_ld) pdr <= bus.data_in;
      if (tx_overflow) tx_ovr <= 1'b1;
      else if (pdr_ld) tx_ovr <= 1'b0;
    end
  end

  // RX holding register: loopback or external capture fill it, CPU pop empties it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_hold  <= '0;
      rx_avail <= 1'b0;
    end else if (loop_xfer) begin
      rx_hold  <= fifo_head;
      rx_avail <= 1'b1;
    end else if (rx_cap) begin
      rx_hold  <= bus.ext_rx_data;
      rx_avail <= 1'b1;
    end else if (rx_pop) begin
      rx_avail <= 1'b0;
    end
  end

  assign bus.ext_tx_data  = fifo_head;
  assign bus.ext_tx_valid = tx_valid;
  assign bus.ext_rx_ready = rx_ready;
  assign bus.data_oe      = bus.port_rd;
  assign bus.data_out     = (bus.port_rd && rx_avail) ? rx_hold : '0;
  assign bus.status       = {rx_avail, tx_ovr, fifo_full, fifo_empty};

endmodule
